// File: rtl/pixel_line_buffer.sv
// Double-banked line buffer between a pixel-pair producer and the LVDS timing stage.
// The producer fills the write bank while the LVDS stage reads the other bank; banks swap at end of line.
module pixel_line_buffer #(
  parameter int H_ACTIVE = 960,
  parameter int ADDR_W   = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [47:0] i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [11:0] i_x,
  output logic [23:0] o_color,
  output logic [23:0] o_color_even,
  output logic        o_line_swap,
  output logic        o_underflow,
  input  logic        i_clear_underflow
);

  localparam logic [11:0]       X_LAST   = 12'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(H_ACTIVE - 1);

  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wr_full_q, wr_full_d;
  logic              rb_valid_q, rb_valid_d;
  logic [11:0]       x_d_q, x_d_d;
  logic              underflow_q, underflow_d;
  logic              line_swap_q, line_swap_d;
  logic              rd_qual_q, rd_qual_d;

  // Bank select is the address MSB: {bank, index}.
  logic [47:0]       mem [0:(2**(ADDR_W+1))-1];
  logic [47:0]       rd_data_q;

  logic              wr_en;
  logic              fill;
  logic              eol;
  logic              set_uf;
  logic              x_in_range;
  logic [11:0]       x_m1;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    wb_d        = wb_q;
    wr_ptr_d    = wr_ptr_q;
    wr_full_d   = wr_full_q;
    rb_valid_d  = rb_valid_q;
    underflow_d = underflow_q;
    line_swap_d = 1'b0;
    x_d_d       = i_x;

    wr_en      = i_wr_valid && !wr_full_q;
    fill       = wr_en && (wr_ptr_q == PTR_LAST);
    eol        = (x_d_q == X_LAST) && (i_x == 12'd0);
    x_in_range = (i_x != 12'd0) && (i_x <= X_LAST);
    x_m1       = i_x - 12'd1;
    rd_addr    = x_m1[ADDR_W-1:0];
    rd_qual_d  = x_in_range && rb_valid_q;

    if (wr_en) begin
      if (fill) begin
        wr_ptr_d  = '0;
        wr_full_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end

    // A write completing the bank on the EOL cycle still counts as a full line.
    set_uf = 1'b0;
    if (eol) begin
      if (wr_full_q || fill) begin
        wb_d        = ~wb_q;
        wr_full_d   = 1'b0;
        rb_valid_d  = 1'b1;
        line_swap_d = 1'b1;
      end else begin
        set_uf = 1'b1;
      end
    end

    if (set_uf) begin
      underflow_d = 1'b1;
    end else if (i_clear_underflow) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wb_q        <= 1'b0;
      wr_ptr_q    <= '0;
      wr_full_q   <= 1'b0;
      rb_valid_q  <= 1'b0;
      x_d_q       <= '0;
      underflow_q <= 1'b0;
      line_swap_q <= 1'b0;
      rd_qual_q   <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_full_q   <= wr_full_d;
      rb_valid_q  <= rb_valid_d;
      x_d_q       <= x_d_d;
      underflow_q <= underflow_d;
      line_swap_q <= line_swap_d;
      rd_qual_q   <= rd_qual_d;
    end
  end

  // Memory has no reset so it maps onto block RAM; reads are masked by rd_qual_q instead.
  always_ff @(posedge i_clk) begin
    if (wr_en && !i_reset) begin
      mem[{wb_q, wr_ptr_q}] <= i_wr_data;
    end
    rd_data_q <= mem[{~wb_q, rd_addr}];
  end

  assign o_wr_ready   = ~wr_full_q;
  assign o_color      = rd_qual_q ? rd_data_q[47:24] : 24'd0;
  assign o_color_even = rd_qual_q ? rd_data_q[23:0]  : 24'd0;
  assign o_line_swap  = line_swap_q;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_pixel_line_buffer.sv
// Directed sequence with random pixel data, checked every cycle against a line-level model
// (a queue of pending words and an array holding the line on display).
module tb_pixel_line_buffer;

  localparam int H = 960;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [47:0] i_wr_data;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [11:0] i_x;
  logic [23:0] o_color;
  logic [23:0] o_color_even;
  logic        o_line_swap;
  logic        o_underflow;
  logic        i_clear_underflow;

  always #5 clk = ~clk;

  pixel_line_buffer #(.H_ACTIVE(H), .ADDR_W(10)) dut (
    .i_clk             (clk),
    .i_reset           (i_reset),
    .i_wr_data         (i_wr_data),
    .i_wr_valid        (i_wr_valid),
    .o_wr_ready        (o_wr_ready),
    .i_x               (i_x),
    .o_color           (o_color),
    .o_color_even      (o_color_even),
    .o_line_swap       (o_line_swap),
    .o_underflow       (o_underflow),
    .i_clear_underflow (i_clear_underflow)
  );

  // Reference model: words accepted for the next line, and the line being displayed.
  logic [47:0] exp_q[$];
  logic [47:0] disp [H];
  bit          disp_valid;
  bit          exp_uf;
  int          xd;
  int          swaps_seen;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    disp_valid = 1'b0;
    exp_uf     = 1'b0;
    xd         = 0;
  endtask

  task automatic do_reset();
    i_reset           = 1'b1;
    i_wr_valid        = 1'b0;
    i_x               = 12'd0;
    i_clear_underflow = 1'b0;
    #1;
    check("rst_color",     48'(o_color),      48'd0);
    check("rst_color_even", 48'(o_color_even), 48'd0);
    check("rst_wr_ready",  48'(o_wr_ready),   48'd1);
    check("rst_underflow", 48'(o_underflow),  48'd0);
    check("rst_line_swap", 48'(o_line_swap),  48'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  // One clock: drive inputs, predict, advance model, compare after the edge.
  task automatic step(input bit valid, input int x, input bit clr);
    logic [47:0] d;
    logic [47:0] exp_c;
    bit          eol, full, exp_sw;
    d = {16'($urandom), 32'($urandom)};
    i_wr_valid        = valid;
    i_wr_data         = d;
    i_x               = 12'(x);
    i_clear_underflow = clr;
    #1;
    check("wr_ready", 48'(o_wr_ready), 48'(exp_q.size() < H));
    if (valid && exp_q.size() < H) exp_q.push_back(d);
    eol    = (xd == H) && (x == 0);
    full   = (exp_q.size() == H);
    exp_c  = (x >= 1 && x <= H && disp_valid) ? disp[x-1] : 48'd0;
    exp_sw = eol && full;
    if (exp_sw) begin
      for (int i = 0; i < H; i++) disp[i] = exp_q[i];
      exp_q.delete();
      disp_valid = 1'b1;
    end
    if (eol && !full) exp_uf = 1'b1;
    else if (clr)     exp_uf = 1'b0;
    xd = x;
    @(posedge clk);
    #1;
    check("color",      48'(o_color),      48'(exp_c[47:24]));
    check("color_even", 48'(o_color_even), 48'(exp_c[23:0]));
    check("line_swap",  48'(o_line_swap),  48'(exp_sw));
    check("underflow",  48'(o_underflow),  48'(exp_uf));
    if (o_line_swap) swaps_seen++;
  endtask

  // Write modes: 0 none, 1 always, 2 random, 3 hold back the last word until the EOL cycle.
  function automatic bit want(input int mode, input bit at_eol);
    case (mode)
      1:       want = 1'b1;
      2:       want = 1'($urandom_range(0, 1));
      3:       want = at_eol ? 1'b1 : (exp_q.size() < H - 1);
      default: want = 1'b0;
    endcase
  endfunction

  task automatic sweep(input int mode, input bit stray);
    for (int x = 1; x <= H; x++) step(want(mode, 1'b0), x, 1'b0);
    if (stray) step(want(mode, 1'b0), 4095, 1'b0);
    step(want(mode, 1'b1), 0, 1'b0);
    for (int i = 0; i < 2; i++) step(want(mode, 1'b0), 0, 1'b0);
  endtask

  task automatic fill(input int n, input int mode);
    for (int i = 0; i < n; i++) step(want(mode, 1'b0), 0, 1'b0);
  endtask

  initial begin
    i_reset           = 1'b1;
    i_wr_valid        = 1'b0;
    i_wr_data         = '0;
    i_x               = '0;
    i_clear_underflow = 1'b0;
    swaps_seen        = 0;
    model_reset();
    #1;
    do_reset();

    // No writes: three sweeps, outputs silent, underflow after first EOL, no swap.
    sweep(0, 1'b0);
    sweep(0, 1'b0);
    sweep(0, 1'b0);
    check("no_swap_without_data", 48'(swaps_seen), 48'd0);
    step(1'b0, 0, 1'b1);

    // Fill one line (random gaps), swap, then read it back.
    while (exp_q.size() < H) step(want(2, 1'b0), 0, 1'b0);
    sweep(0, 1'b0);
    check("first_swap", 48'(swaps_seen), 48'd1);
    sweep(0, 1'b0);

    // Full bank with valid held high through a sweep: back-pressure, then refill.
    fill(H + 20, 1);
    sweep(1, 1'b0);

    // Out-of-range x: masked outputs and no EOL.
    sweep(2, 1'b1);

    // Drain any partial line through one swap, then land the last write on EOL.
    while (exp_q.size() < H) step(1'b1, 0, 1'b0);
    sweep(0, 1'b0);
    sweep(3, 1'b0);
    sweep(0, 1'b0);

    // Underflow with same-cycle clear at EOL: set must win.
    for (int x = 1; x <= H; x++) step(1'b0, x, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    // Reset mid-line after 500 writes and while outputs are live.
    fill(500, 1);
    for (int x = 1; x <= 300; x++) step(1'b0, x, 1'b0);
    do_reset();
    fill(H, 1);
    sweep(0, 1'b0);
    sweep(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
